traffic_light_monitor: RTL and testbench
========================================

Name: traffic_light_monitor

Overview:
Sits at the receiving end of the 2-bit traffic light code bus (00=Red, 01=Green, 10=Yellow) driven by the intersection controller. Decodes the code into one-hot lamp drives and checks that the sequence is legal and that dwell times stay in bounds. On any violation it latches a fault and forces the lamps into failsafe flashing red until the fault is cleared. It also keeps a count of completed light cycles for the status logic.

Parameters:
MIN_DWELL, 1, minimum number of consecutive cycles a code must be held before a change is legal (>=1)
MAX_DWELL, 16, maximum number of consecutive cycles a code may be held (> MIN_DWELL)
FLASH_DIV, 4, failsafe red lamp half-period in cycles (>=1)
CNT_W, 16, width of cycle_count

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
light  input  2  light code from controller; sampled every rising edge
clear_fault  input  1  one-cycle pulse; leaves failsafe
lamp_red  output  1  red lamp drive
lamp_yellow  output  1  yellow lamp drive
lamp_green  output  1  green lamp drive
fault  output  1  sticky fault flag
fault_code  output  2  00 none, 01 ILLEGAL, 10 SHORT, 11 STUCK
cycle_count  output  CNT_W  completed R->G->Y->R cycles, wraps modulo 2^CNT_W

Behaviour:
- One clock domain; reset is synchronous and active-high; all outputs registered.
- Reset (wins over every other input): state=WAIT_RED; lamp_red=1, lamp_yellow=0, lamp_green=0, fault=0, fault_code=00, cycle_count=0, dwell=0, flash phase cleared.
- Internal: prev (last accepted code), dwell (saturating, width clog2(MAX_DWELL+1)), flash counter.
- WAIT_RED: lamp_red=1 steady, others 0. When light==00 is sampled -> RUN, prev=00, dwell=1. Any other sample increments dwell. If MAX_DWELL consecutive non-Red samples occur without a Red -> FAULT, code 11.
- RUN, at each edge:
  - If light==prev: dwell+1. If dwell was already MAX_DWELL -> FAULT, code 11. A code held MAX_DWELL cycles is legal; MAX_DWELL+1 is a fault.
  - If light!=prev: legal next codes are 00->01, 01->10, 10->00.
    - If the code is 11 or the transition is illegal -> FAULT, code 01.
    - Else if dwell<MIN_DWELL -> FAULT, code 10.
    - Else accept: prev=light, dwell=1. If the transition is 10->00, cycle_count+1.
  - Fault priority when several conditions hold on the same edge: ILLEGAL > SHORT > STUCK.
  - Lamps are a one-hot decode of the sampled light code. Each lamp follows the light sampled at the previous edge (1-cycle latency).
- Fault timing: fault and fault_code take effect on the same edge that samples the offending code. From that edge the lamps show failsafe, and the offending code is never decoded onto the lamps.
- FAULT:
  - lamp_yellow=lamp_green=0.
  - lamp_red=1 for FLASH_DIV cycles, then 0 for FLASH_DIV cycles, repeating. The first on-phase starts at fault entry.
  - fault, fault_code and cycle_count hold; light is ignored.
- Leaving FAULT: clear_fault=1 -> WAIT_RED with fault=0, fault_code=00, dwell=0, lamp_red=1 steady; cycle_count is preserved. clear_fault outside FAULT is ignored.
- reset asserted at any point, including mid-FAULT or together with clear_fault: the reset values apply on that edge.
- Never more than one lamp on at once.

Test Plan:
- Reset, then light=00,01,10,00,01,10,00 one cycle each (defaults) -> fault=0; lamps one-hot R,G,Y,R,G,Y,R, each one cycle after its sample; cycle_count=2.
- Running normally with prev=00, drive light=10 -> fault=1, fault_code=01 on that edge; lamp_red high for 4 cycles and low for 4 cycles, repeating; yellow/green stay 0.
- MIN_DWELL=3: 00 for 3 cycles, 01 for 2 cycles, then 10 -> fault_code=10 on the 10 sample. Repeat with 01 held for 3 cycles -> no fault.
- Hold 01 for exactly 16 cycles, then 10 -> no fault. Hold 01 for 17 cycles -> fault_code=11 on the 17th sample. Hold reset-exit light=01 for 16 cycles -> fault_code=11.
- Drive light=11 -> fault_code=01. Pulse clear_fault with light=01 -> fault=0, code 00, lamp_red steady, state WAIT_RED. Then light=00 -> RUN; cycle_count unchanged from before the fault.
- Assert reset mid-RUN, mid-FAULT, and together with clear_fault -> after that edge: lamp_red=1, others 0, fault=0, fault_code=00, cycle_count=0.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Receiver-side monitor for the 2-bit traffic light bus: decodes lamps, checks
// sequence legality and dwell bounds, and falls back to flashing red on a fault.
module traffic_light_monitor #(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 16,
  parameter int FLASH_DIV = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       light,
  input  logic             clear_fault,
  output logic             lamp_red,
  output logic             lamp_yellow,
  output logic             lamp_green,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DW = $clog2(MAX_DWELL + 1);
  localparam int FW = $clog2(FLASH_DIV + 1);
  localparam logic [DW-1:0] MAX_D      = DW'(MAX_DWELL);
  localparam logic [DW-1:0] MIN_D      = DW'(MIN_DWELL);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

  localparam logic [1:0] L_RED    = 2'b00;
  localparam logic [1:0] L_GREEN  = 2'b01;
  localparam logic [1:0] L_YELLOW = 2'b10;

  localparam logic [1:0] F_NONE    = 2'b00;
  localparam logic [1:0] F_ILLEGAL = 2'b01;
  localparam logic [1:0] F_SHORT   = 2'b10;
  localparam logic [1:0] F_STUCK   = 2'b11;

  typedef enum logic [1:0] {WAIT_RED, RUN, FAULT} state_t;

  state_t           r_state;
  logic [1:0]       r_prev;
  logic [DW-1:0]    r_dwell;
  logic [FW-1:0]    r_flash;
  logic [2:0]       r_lamps;
  logic             r_fault;
  logic [1:0]       r_code;
  logic [CNT_W-1:0] r_count;

  logic       w_legal;
  logic [2:0] w_decode;
  logic       w_raise;
  logic [1:0] w_code;

  assign w_legal = (r_prev == L_RED    && light == L_GREEN)  ||
                   (r_prev == L_GREEN  && light == L_YELLOW) ||
                   (r_prev == L_YELLOW && light == L_RED);
  assign w_decode = {light == L_RED, light == L_YELLOW, light == L_GREEN};

  // Fault detection for the current sample; illegal codes outrank short dwell.
  always_comb begin
    w_raise = 1'b0;
    w_code  = F_NONE;
    case (r_state)
      WAIT_RED: begin
        if (light != L_RED && r_dwell == MAX_D - DW'(1)) begin
          w_raise = 1'b1;
          w_code  = F_STUCK;
        end
      end
      RUN: begin
        if (light == r_prev) begin
          if (r_dwell == MAX_D) begin
            w_raise = 1'b1;
            w_code  = F_STUCK;
          end
        end else if (!w_legal) begin
          w_raise = 1'b1;
          w_code  = F_ILLEGAL;
        end else if (r_dwell < MIN_D) begin
          w_raise = 1'b1;
          w_code  = F_SHORT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= WAIT_RED;
      r_prev  <= L_RED;
      r_dwell <= '0;
      r_flash <= '0;
      r_lamps <= 3'b100;
      r_fault <= 1'b0;
      r_code  <= F_NONE;
      r_count <= '0;
    end else if (w_raise) begin
      // The offending code never reaches the lamps; flashing starts on-phase.
      r_state <= FAULT;
      r_fault <= 1'b1;
      r_code  <= w_code;
      r_lamps <= 3'b100;
      r_flash <= '0;
    end else begin
      case (r_state)
        WAIT_RED: begin
          r_lamps <= 3'b100;
          if (light == L_RED) begin
            r_state <= RUN;
            r_prev  <= L_RED;
            r_dwell <= DW'(1);
          end else if (r_dwell != MAX_D) begin
            r_dwell <= r_dwell + DW'(1);
          end
        end
        RUN: begin
          r_lamps <= w_decode;
          if (light == r_prev) begin
            if (r_dwell != MAX_D) r_dwell <= r_dwell + DW'(1);
          end else begin
            r_prev  <= light;
            r_dwell <= DW'(1);
            if (r_prev == L_YELLOW) r_count <= r_count + CNT_W'(1);
          end
        end
        FAULT: begin
          if (clear_fault) begin
            r_state <= WAIT_RED;
            r_fault <= 1'b0;
            r_code  <= F_NONE;
            r_dwell <= '0;
            r_flash <= '0;
            r_lamps <= 3'b100;
          end else if (r_flash == FLASH_LAST) begin
            r_flash <= '0;
            r_lamps <= {~r_lamps[2], 2'b00};
          end else begin
            r_flash <= r_flash + FW'(1);
          end
        end
        default: r_state <= WAIT_RED;
      endcase
    end
  end

  assign lamp_red    = r_lamps[2];
  assign lamp_yellow = r_lamps[1];
  assign lamp_green  = r_lamps[0];
  assign fault       = r_fault;
  assign fault_code  = r_code;
  assign cycle_count = r_count;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: a vector table for the main flow
// plus hand-written sequences for dwell limits (default and MIN_DWELL=3 copies).
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  light;
  logic        clear_fault;

  logic        red0, yel0, grn0, flt0;
  logic [1:0]  code0;
  logic [15:0] cnt0;
  logic        red3, yel3, grn3, flt3;
  logic [1:0]  code3;
  logic [15:0] cnt3;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [1:0]  light;
    logic        clr;
    logic        rst;
    logic [21:0] expOut;
  } vec_t;

  vec_t vecs[$];

  traffic_light_monitor dut (
    .clk(clk), .reset(reset), .light(light), .clear_fault(clear_fault),
    .lamp_red(red0), .lamp_yellow(yel0), .lamp_green(grn0),
    .fault(flt0), .fault_code(code0), .cycle_count(cnt0)
  );

  traffic_light_monitor #(.MIN_DWELL(3)) dut3 (
    .clk(clk), .reset(reset), .light(light), .clear_fault(clear_fault),
    .lamp_red(red3), .lamp_yellow(yel3), .lamp_green(grn3),
    .fault(flt3), .fault_code(code3), .cycle_count(cnt3)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] pk(input logic r, input logic y, input logic g,
                                     input logic f, input logic [1:0] c,
                                     input logic [15:0] n);
    return {r, y, g, f, c, n};
  endfunction

  function automatic logic [21:0] out0();
    return {red0, yel0, grn0, flt0, code0, cnt0};
  endfunction

  function automatic logic [21:0] out3();
    return {red3, yel3, grn3, flt3, code3, cnt3};
  endfunction

  task automatic addVec(input logic [1:0] l, input logic c, input logic r,
                        input logic [21:0] e);
    vec_t v;
    v.light = l; v.clr = c; v.rst = r; v.expOut = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [1:0] l, input logic c, input logic r);
    light = l;
    clear_fault = c;
    reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic holdLight(input logic [1:0] l, input int n);
    for (int k = 0; k < n; k++) applyStimulus(l, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [21:0] got,
                             input logic [21:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got r/y/g/f/code/cnt=%b/%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%b/%0d",
               name, got[21], got[20], got[19], got[18], got[17:16], got[15:0],
               exp[21], exp[20], exp[19], exp[18], exp[17:16], exp[15:0]);
    end
  endtask

  initial begin
    light = 2'b00;
    clear_fault = 1'b0;
    reset = 1'b1;

    // Main flow: two full cycles, illegal jump, flashing, clear, resets.
    addVec(2'b00, 0, 1, pk(1,0,0,0,2'b00,0));
    addVec(2'b00, 0, 0, pk(1,0,0,0,2'b00,0));
    addVec(2'b01, 0, 0, pk(0,0,1,0,2'b00,0));
    addVec(2'b10, 0, 0, pk(0,1,0,0,2'b00,0));
    addVec(2'b00, 0, 0, pk(1,0,0,0,2'b00,1));
    addVec(2'b01, 1, 0, pk(0,0,1,0,2'b00,1));
    addVec(2'b10, 0, 0, pk(0,1,0,0,2'b00,1));
    addVec(2'b00, 0, 0, pk(1,0,0,0,2'b00,2));
    addVec(2'b10, 0, 0, pk(1,0,0,1,2'b01,2));
    for (int k = 0; k < 3; k++) addVec(2'b10, 0, 0, pk(1,0,0,1,2'b01,2));
    for (int k = 0; k < 4; k++) addVec(2'b10, 0, 0, pk(0,0,0,1,2'b01,2));
    addVec(2'b10, 0, 0, pk(1,0,0,1,2'b01,2));
    addVec(2'b01, 1, 0, pk(1,0,0,0,2'b00,2));
    addVec(2'b01, 0, 0, pk(1,0,0,0,2'b00,2));
    addVec(2'b00, 0, 0, pk(1,0,0,0,2'b00,2));
    addVec(2'b01, 0, 0, pk(0,0,1,0,2'b00,2));
    addVec(2'b11, 0, 0, pk(1,0,0,1,2'b01,2));
    addVec(2'b01, 1, 1, pk(1,0,0,0,2'b00,0));
    addVec(2'b00, 0, 0, pk(1,0,0,0,2'b00,0));
    addVec(2'b01, 0, 0, pk(0,0,1,0,2'b00,0));
    addVec(2'b01, 0, 1, pk(1,0,0,0,2'b00,0));
    addVec(2'b00, 0, 0, pk(1,0,0,0,2'b00,0));
    addVec(2'b10, 0, 0, pk(1,0,0,1,2'b01,0));
    for (int k = 0; k < 3; k++) addVec(2'b00, 0, 0, pk(1,0,0,1,2'b01,0));
    addVec(2'b00, 0, 0, pk(0,0,0,1,2'b01,0));
    addVec(2'b00, 0, 1, pk(1,0,0,0,2'b00,0));

    @(negedge clk);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].light, vecs[i].clr, vecs[i].rst);
      checkOutput($sformatf("vec[%0d]", i), out0(), vecs[i].expOut);
    end

    // Hold green exactly MAX_DWELL cycles, then a legal change.
    applyStimulus(2'b00, 0, 1);
    holdLight(2'b00, 1);
    holdLight(2'b01, 16);
    checkOutput("hold16_green", out0(), pk(0,0,1,0,2'b00,0));
    holdLight(2'b10, 1);
    checkOutput("hold16_then_yellow", out0(), pk(0,1,0,0,2'b00,0));

    // One sample past MAX_DWELL is a stuck fault.
    applyStimulus(2'b00, 0, 1);
    holdLight(2'b00, 1);
    holdLight(2'b01, 16);
    checkOutput("hold17_pre", out0(), pk(0,0,1,0,2'b00,0));
    holdLight(2'b01, 1);
    checkOutput("hold17_stuck", out0(), pk(1,0,0,1,2'b11,0));

    // No red ever arrives after reset.
    applyStimulus(2'b00, 0, 1);
    holdLight(2'b01, 15);
    checkOutput("waitred_15", out0(), pk(1,0,0,0,2'b00,0));
    holdLight(2'b01, 1);
    checkOutput("waitred_16_stuck", out0(), pk(1,0,0,1,2'b11,0));

    // MIN_DWELL=3: green held two cycles is too short.
    applyStimulus(2'b00, 0, 1);
    holdLight(2'b00, 3);
    holdLight(2'b01, 2);
    checkOutput("min3_green", out3(), pk(0,0,1,0,2'b00,0));
    holdLight(2'b10, 1);
    checkOutput("min3_short", out3(), pk(1,0,0,1,2'b10,0));
    checkOutput("min1_same_seq", out0(), pk(0,1,0,0,2'b00,0));

    // MIN_DWELL=3: green held three cycles is fine.
    applyStimulus(2'b00, 0, 1);
    holdLight(2'b00, 3);
    holdLight(2'b01, 3);
    holdLight(2'b10, 1);
    checkOutput("min3_ok", out3(), pk(0,1,0,0,2'b00,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
